// File: rtl/bus1_pkg.sv
// bus1_pkg: shared bus1 command codes, default widths and responder state encoding.
package bus1_pkg;
    localparam int DEF_TAG_SIZE    = 10;
    localparam int DEF_SET_SIZE    = 5;
    localparam int DEF_OFFSET_SIZE = 4;
    localparam int DEF_ADDR1_SIZE  = DEF_TAG_SIZE + DEF_SET_SIZE;
    localparam int DEF_DATA_SIZE   = 16;
    localparam int DEF_CTR1_SIZE   = 3;
    localparam logic [2:0] C1_NOP             = 3'd0;
    localparam logic [2:0] C1_READ8           = 3'd1;
    localparam logic [2:0] C1_READ16          = 3'd2;
    localparam logic [2:0] C1_READ32          = 3'd3;
    localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8          = 3'd5;
    localparam logic [2:0] C1_WRITE16         = 3'd6;
    localparam logic [2:0] C1_WRITE32         = 3'd7;
    localparam logic [2:0] C1_RESPONSE        = 3'd7;
    typedef enum logic [2:0] {IDLE, ADDR2, REQ, WAIT, RESP, TURN} state_t;
endpackage

// File: rtl/bus1_driver.sv
// bus1_driver: tri-state stage for the bus1 C1/D1 lines; both float whenever the responder is not driving.
module bus1_driver #(
    parameter int CW = 3,
    parameter int DW = 16
) (
    input  logic          i_drive_en,
    input  logic          i_d_en,
    input  logic [CW-1:0] i_c_val,
    input  logic [DW-1:0] i_d_val,
    output wire  [CW-1:0] o_c,
    output wire  [DW-1:0] o_d
);
    assign o_c = i_drive_en ? i_c_val : {CW{1'bz}};
    assign o_d = (i_drive_en && i_d_en) ? i_d_val : {DW{1'bz}};
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: cache-side bus1 terminator; parses the two-tick CPU request and returns the core's result.
// Define BUS1_PROTOCOL_CHECK_EN to enable the sticky protocol monitor on proto_err.
module cpu_bus_responder
    import bus1_pkg::*;
#(
    parameter int CACHE_TAG_SIZE    = DEF_TAG_SIZE,
    parameter int CACHE_SET_SIZE    = DEF_SET_SIZE,
    parameter int CACHE_OFFSET_SIZE = DEF_OFFSET_SIZE,
    parameter int ADDR1_BUS_SIZE    = DEF_ADDR1_SIZE,
    parameter int DATA_BUS_SIZE     = DEF_DATA_SIZE,
    parameter int CTR1_BUS_SIZE     = DEF_CTR1_SIZE
) (
    input  logic                                                   CLK,
    input  logic                                                   RESET,
    input  logic [ADDR1_BUS_SIZE-1:0]                              A1,
    inout  wire  [DATA_BUS_SIZE-1:0]                               D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]                               C1,
    output logic                                                   req_valid,
    input  logic                                                   req_ready,
    output logic [CTR1_BUS_SIZE-1:0]                               req_cmd,
    output logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr,
    output logic [31:0]                                            req_wdata,
    input  logic                                                   resp_valid,
    input  logic [31:0]                                            resp_rdata,
    output logic                                                   proto_err
);
    localparam int AW = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
    state_t r_state, w_next;
    logic [CTR1_BUS_SIZE-1:0] r_cmd;
    logic [AW-1:0]            r_addr;
    logic [31:0]              r_wdata, r_rdata;
    logic                     r_beat;
    logic                     w_c_en, w_d_en;
    logic [DATA_BUS_SIZE-1:0] w_d_val;

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) r_state <= IDLE;
        else r_state <= w_next;

    // if-form in IDLE so a floating C1 is treated as NOP rather than poisoning the state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (C1 != C1_NOP) w_next = ADDR2;
            ADDR2:   w_next = REQ;
            REQ:     w_next = req_ready ? WAIT : REQ;
            WAIT:    w_next = resp_valid ? RESP : WAIT;
            RESP:    w_next = (r_cmd == C1_READ32 && !r_beat) ? RESP : TURN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_valid = r_state == REQ;
        w_c_en    = r_state == RESP;
        w_d_en    = r_cmd inside {C1_READ8, C1_READ16, C1_READ32};
        w_d_val   = r_cmd == C1_READ8 ? {8'h00, r_rdata[7:0]} : r_beat ? r_rdata[31:16] : r_rdata[15:0];
    end

    // r_beat marks the second RESP cycle, which only READ32 reaches
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_beat  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == ADDR2) begin
                r_cmd   <= C1;
                r_addr  <= {A1, {CACHE_OFFSET_SIZE{1'b0}}};
                r_wdata <= 32'(D1);
            end
            if (r_state == ADDR2) begin
                r_addr[CACHE_OFFSET_SIZE-1:0] <= A1[CACHE_OFFSET_SIZE-1:0];
                if (r_cmd == C1_WRITE32) r_wdata[31:16] <= D1;
            end
            if (r_state == WAIT && resp_valid) r_rdata <= resp_rdata;
            r_beat <= r_state == RESP && !r_beat;
        end

    assign req_cmd   = r_cmd;
    assign req_addr  = r_addr;
    assign req_wdata = r_wdata;

`ifdef BUS1_PROTOCOL_CHECK_EN
    logic r_err;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) r_err <= 1'b0;
        else if ((r_state == ADDR2 && (C1 != r_cmd || A1[ADDR1_BUS_SIZE-1:CACHE_OFFSET_SIZE] != '0)) ||
                 (r_state == RESP && C1 != C1_RESPONSE)) r_err <= 1'b1;
    assign proto_err = r_err;
`else
    assign proto_err = 1'b0;
`endif

    bus1_driver #(.CW(CTR1_BUS_SIZE), .DW(DATA_BUS_SIZE)) u_drv (
        .i_drive_en(w_c_en),
        .i_d_en    (w_d_en),
        .i_c_val   (C1_RESPONSE),
        .i_d_val   (w_d_val),
        .o_c       (C1),
        .o_d       (D1)
    );
endmodule
